// File: rtl/rv32_pipeline_pkg.sv
// Shared RV32 pipeline types: opcodes, ALU operations, operand selects and the
// per-stage control bundle carried by rv32_pipe_ctrl.
package rv32_pipeline_pkg;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'h03,
    OPC_OP_IMM = 7'h13,
    OPC_AUIPC  = 7'h17,
    OPC_STORE  = 7'h23,
    OPC_OP     = 7'h33,
    OPC_LUI    = 7'h37,
    OPC_BRANCH = 7'h63,
    OPC_JALR   = 7'h67,
    OPC_JAL    = 7'h6F
  } opcode_t;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_A = 4'd10,
    ALU_PASS_B = 4'd11
  } alu_opcode_t;

  typedef enum logic {
    REGISTER_A = 1'b0,
    PC_A       = 1'b1
  } src_a_sel_t;

  typedef enum logic {
    IMMEDIATE  = 1'b0,
    REGISTER_B = 1'b1
  } src_b_sel_t;

  typedef enum logic [2:0] {
    I_TYPE = 3'd0,
    S_TYPE = 3'd1,
    B_TYPE = 3'd2,
    U_TYPE = 3'd3,
    J_TYPE = 3'd4
  } imm_sel_t;

  localparam logic WB_ALU = 1'b0;
  localparam logic WB_MEM = 1'b1;

  typedef struct packed {
    logic        valid;
    alu_opcode_t alu_op;
    src_a_sel_t  src_a_sel;
    src_b_sel_t  src_b_sel;
    imm_sel_t    imm_sel;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        wb_sel;
    logic [4:0]  rd;
    logic        illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{
    valid: 1'b0, alu_op: ALU_ADD, src_a_sel: REGISTER_A, src_b_sel: IMMEDIATE,
    imm_sel: I_TYPE, mem_read: 1'b0, mem_write: 1'b0, reg_write: 1'b0,
    wb_sel: WB_ALU, rd: 5'd0, illegal: 1'b0
  };

  // alt selects the funct7=0x20 variant (SUB for funct3 0, SRA for funct3 5)
  function automatic alu_opcode_t alu_from_funct3(input logic [2:0] funct3, input logic alt);
    alu_opcode_t op;
    case (funct3)
      3'd0:    op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      3'd7:    op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // True when a stage that will write c.rd produces a source the decode slot reads
  function automatic logic rd_hits(input ctrl_t c, input logic [4:0] rs1, input logic rs1_used,
                                   input logic [4:0] rs2, input logic rs2_used);
    return c.valid && c.reg_write && (c.rd != 5'd0) &&
           ((rs1_used && (rs1 == c.rd)) || (rs2_used && (rs2 == c.rd)));
  endfunction

endpackage

// File: rtl/rv32_pipe_ctrl_decode.sv
// Combinational RV32 decoder: instruction fields to a control bundle plus the
// register-source usage flags consumed by the hazard check.
module rv32_ctrl_decode
  import rv32_pipeline_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic [4:0] rd,
  output ctrl_t      ctrl,
  output logic       rs1_used,
  output logic       rs2_used
);

  always_comb begin
    ctrl      = CTRL_BUBBLE;
    ctrl.valid = 1'b1;
    rs1_used  = 1'b0;
    rs2_used  = 1'b0;
    case (opcode)
      OPC_LOAD: begin
        ctrl.mem_read  = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.wb_sel    = WB_MEM;
        rs1_used       = 1'b1;
      end
      OPC_OP_IMM: begin
        ctrl.alu_op    = alu_from_funct3(funct3, (funct3 == 3'd5) && (funct7 == 7'h20));
        ctrl.reg_write = 1'b1;
        rs1_used       = 1'b1;
      end
      OPC_OP: begin
        if ((funct7 == 7'h00) || (funct7 == 7'h20)) begin
          ctrl.alu_op    = alu_from_funct3(funct3, funct7 == 7'h20);
          ctrl.src_b_sel = REGISTER_B;
          ctrl.reg_write = 1'b1;
          rs1_used       = 1'b1;
          rs2_used       = 1'b1;
        end else begin
          ctrl.illegal = 1'b1;
        end
      end
      OPC_STORE: begin
        ctrl.imm_sel   = S_TYPE;
        ctrl.mem_write = 1'b1;
        rs1_used       = 1'b1;
        rs2_used       = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl.imm_sel = B_TYPE;
        rs1_used     = 1'b1;
        rs2_used     = 1'b1;
      end
      OPC_JAL: begin
        ctrl.imm_sel   = J_TYPE;
        ctrl.src_a_sel = PC_A;
        ctrl.reg_write = 1'b1;
      end
      OPC_JALR: begin
        ctrl.reg_write = 1'b1;
        rs1_used       = 1'b1;
      end
      OPC_LUI: begin
        ctrl.imm_sel   = U_TYPE;
        ctrl.alu_op    = ALU_PASS_B;
        ctrl.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl.imm_sel   = U_TYPE;
        ctrl.src_a_sel = PC_A;
        ctrl.reg_write = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
    // x0 is never written, so it must never look like a pending producer
    ctrl.reg_write = ctrl.reg_write && (rd != 5'd0);
    ctrl.rd        = ctrl.reg_write ? rd : 5'd0;
  end

endmodule

// File: rtl/rv32_pipe_ctrl.sv
// Pipelined RV32 control: decode, STAGES-deep control bundle pipe, RAW hazard
// stall of the decode slot, branch flush and saturating stall counter.
// Define RV32_PIPE_FORWARDING_EN when the EX/MEM bypass exists (load-use stalls only).
module rv32_pipe_ctrl
  import rv32_pipeline_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [6:0]        id_opcode,
  input  logic [2:0]        id_funct3,
  input  logic [6:0]        id_funct7,
  input  logic [4:0]        id_rd,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              flush,
  output logic [STAGES-1:0] stage_valid,
  output alu_opcode_t       ex_alu_op,
  output src_a_sel_t        ex_src_a_sel,
  output src_b_sel_t        ex_src_b_sel,
  output imm_sel_t          ex_imm_sel,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic              wb_reg_write_en,
  output logic              wb_sel,
  output logic [4:0]        wb_rd,
  output logic              illegal,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int LAST = STAGES - 1;

  ctrl_t stage [STAGES];
  ctrl_t dec;
  logic  rs1_used;
  logic  rs2_used;
  logic  hit;
  logic  haz;

  rv32_ctrl_decode u_decode (
    .opcode   (id_opcode),
    .funct3   (id_funct3),
    .funct7   (id_funct7),
    .rd       (id_rd),
    .ctrl     (dec),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used)
  );

  // The write-back stage is never compared: the register file writes before it reads
  always_comb begin
    hit = 1'b0;
`ifdef RV32_PIPE_FORWARDING_EN
    hit = stage[0].mem_read && rd_hits(stage[0], id_rs1, rs1_used, id_rs2, rs2_used);
`else
    for (int i = 0; i < STAGES - 1; i++) begin
      hit = hit | rd_hits(stage[i], id_rs1, rs1_used, id_rs2, rs2_used);
    end
`endif
    haz = id_valid && hit;
  end

  assign id_ready = !haz || flush;

  // Stage shift, stage-0 bubble insertion and stall counting
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage[i] <= CTRL_BUBBLE;
      end
      stall_cnt <= '0;
    end else begin
      stage[0] <= (flush || haz || !id_valid) ? CTRL_BUBBLE : dec;
      for (int i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
      if (haz && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end else begin
        stall_cnt <= stall_cnt;
      end
    end
  end

  // Output views of the stage registers, gated by each stage's valid
  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      stage_valid[i] = stage[i].valid;
    end
    ex_alu_op       = stage[0].alu_op;
    ex_src_a_sel    = stage[0].src_a_sel;
    ex_src_b_sel    = stage[0].src_b_sel;
    ex_imm_sel      = stage[0].imm_sel;
    illegal         = stage[0].valid && stage[0].illegal;
    mem_read_en     = stage[1].valid && stage[1].mem_read;
    mem_write_en    = stage[1].valid && stage[1].mem_write;
    wb_reg_write_en = stage[LAST].valid && stage[LAST].reg_write;
    wb_sel          = stage[LAST].valid && stage[LAST].wb_sel;
    wb_rd           = stage[LAST].valid ? stage[LAST].rd : 5'd0;
  end

endmodule

// File: tb/tb_rv32_pipe_ctrl.sv
// Self-checking bench for rv32_pipe_ctrl: instruction-level reference model
// compared every cycle, plus directed literal expectations per scenario.
module tb_rv32_pipe_ctrl;
  import rv32_pipeline_pkg::*;

  localparam int STAGES = 3;
  localparam int CNT_W  = 4;
  localparam int SAT    = (1 << CNT_W) - 1;
`ifdef RV32_PIPE_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [6:0] O_LOAD = 7'h03, O_IMM = 7'h13, O_AUIPC = 7'h17, O_STORE = 7'h23;
  localparam logic [6:0] O_OP = 7'h33, O_LUI = 7'h37, O_BR = 7'h63, O_JALR = 7'h67, O_JAL = 7'h6F;

  logic clk, rst, id_valid, id_ready, flush;
  logic [6:0] id_opcode, id_funct7;
  logic [2:0] id_funct3;
  logic [4:0] id_rd, id_rs1, id_rs2;
  logic [STAGES-1:0] stage_valid;
  alu_opcode_t ex_alu_op;
  src_a_sel_t  ex_src_a_sel;
  src_b_sel_t  ex_src_b_sel;
  imm_sel_t    ex_imm_sel;
  logic mem_read_en, mem_write_en, wb_reg_write_en, wb_sel, illegal;
  logic [4:0] wb_rd;
  logic [CNT_W-1:0] stall_cnt;

  rv32_pipe_ctrl #(.STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7(id_funct7),
    .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .flush(flush),
    .stage_valid(stage_valid), .ex_alu_op(ex_alu_op), .ex_src_a_sel(ex_src_a_sel),
    .ex_src_b_sel(ex_src_b_sel), .ex_imm_sel(ex_imm_sel), .mem_read_en(mem_read_en),
    .mem_write_en(mem_write_en), .wb_reg_write_en(wb_reg_write_en), .wb_sel(wb_sel),
    .wb_rd(wb_rd), .illegal(illegal), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model: raw instructions in flight ----------------
  typedef struct packed {
    logic       v;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd;
  } minst_t;

  minst_t pipe [STAGES];
  int     m_stalls = 0;
  bit     m_live = 1'b0;
  int     cyc = 0;
  int     n_checks = 0;
  int     n_errors = 0;
  logic [4:0] wb_log [16];
  logic       wbw_log [16];
  logic       sv0_log [16];

  function automatic bit legal(input logic [6:0] opc, input logic [6:0] f7);
    case (opc)
      O_LOAD, O_IMM, O_AUIPC, O_STORE, O_LUI, O_BR, O_JALR, O_JAL: return 1'b1;
      O_OP:    return (f7 == 7'h00) || (f7 == 7'h20);
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit writes(input minst_t m);
    return m.v && legal(m.opc, m.f7) && (m.rd != 5'd0) &&
           (m.opc inside {O_LOAD, O_IMM, O_AUIPC, O_OP, O_LUI, O_JALR, O_JAL});
  endfunction

  function automatic alu_opcode_t exp_alu(input minst_t m);
    alu_opcode_t tbl [8];
    tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    if (!m.v || !legal(m.opc, m.f7)) return ALU_ADD;
    if (m.opc == O_LUI) return ALU_PASS_B;
    if (m.opc != O_OP && m.opc != O_IMM) return ALU_ADD;
    if (m.f7 == 7'h20 && m.f3 == 3'd5) return ALU_SRA;
    if (m.f7 == 7'h20 && m.f3 == 3'd0 && m.opc == O_OP) return ALU_SUB;
    return tbl[m.f3];
  endfunction

  function automatic imm_sel_t exp_imm(input minst_t m);
    if (!m.v) return I_TYPE;
    case (m.opc)
      O_STORE:        return S_TYPE;
      O_BR:           return B_TYPE;
      O_JAL:          return J_TYPE;
      O_LUI, O_AUIPC: return U_TYPE;
      default:        return I_TYPE;
    endcase
  endfunction

  // A used nonzero source matching a pending writer in any non-WB stage (load in EX only when bypassed)
  function automatic bit m_haz();
    bit u1, u2, h;
    h  = 1'b0;
    u1 = legal(id_opcode, id_funct7) && (id_opcode inside {O_OP, O_IMM, O_LOAD, O_STORE, O_BR, O_JALR});
    u2 = legal(id_opcode, id_funct7) && (id_opcode inside {O_OP, O_STORE, O_BR});
    if (id_valid !== 1'b1) return 1'b0;
    for (int i = 0; i < STAGES - 1; i++) begin
      if (writes(pipe[i]) && (!FWD || (i == 0 && pipe[i].opc == O_LOAD)) &&
          ((u1 && id_rs1 != 5'd0 && id_rs1 == pipe[i].rd) ||
           (u2 && id_rs2 != 5'd0 && id_rs2 == pipe[i].rd)))
        h = 1'b1;
    end
    return h;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) pipe[i] <= '0;
      m_stalls <= 0;
      m_live   <= 1'b1;
      cyc      <= 0;
    end else begin
      pipe[0] <= (flush || m_haz() || !id_valid) ? minst_t'('0)
               : minst_t'({1'b1, id_opcode, id_funct3, id_funct7, id_rd});
      for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
      if (m_haz() && !flush) m_stalls <= m_stalls + 1;
      cyc <= cyc + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input int exp);
    n_checks++;
    if (got !== 32'(exp)) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Compare every DUT output against the model on the falling edge
  always @(negedge clk) begin
    if (m_live) begin
      for (int i = 0; i < STAGES; i++) chk($sformatf("stage_valid[%0d]", i), 32'(stage_valid[i]), int'(pipe[i].v));
      chk("id_ready", 32'(id_ready), int'(!m_haz() || flush));
      chk("ex_alu_op", 32'(ex_alu_op), int'(exp_alu(pipe[0])));
      chk("ex_src_a_sel", 32'(ex_src_a_sel),
          int'(pipe[0].v && (pipe[0].opc == O_AUIPC || pipe[0].opc == O_JAL)));
      chk("ex_src_b_sel", 32'(ex_src_b_sel),
          int'(pipe[0].v && pipe[0].opc == O_OP && legal(pipe[0].opc, pipe[0].f7)));
      chk("ex_imm_sel", 32'(ex_imm_sel), int'(exp_imm(pipe[0])));
      chk("illegal", 32'(illegal), int'(pipe[0].v && !legal(pipe[0].opc, pipe[0].f7)));
      chk("mem_read_en", 32'(mem_read_en), int'(pipe[1].v && pipe[1].opc == O_LOAD));
      chk("mem_write_en", 32'(mem_write_en), int'(pipe[1].v && pipe[1].opc == O_STORE));
      chk("wb_reg_write_en", 32'(wb_reg_write_en), int'(writes(pipe[STAGES-1])));
      chk("wb_sel", 32'(wb_sel), int'(pipe[STAGES-1].v && pipe[STAGES-1].opc == O_LOAD));
      chk("wb_rd", 32'(wb_rd), writes(pipe[STAGES-1]) ? int'(pipe[STAGES-1].rd) : 0);
      chk("stall_cnt", 32'(stall_cnt), (m_stalls > SAT) ? SAT : m_stalls);
    end
    if (cyc < 16) begin
      wb_log[cyc]  <= wb_rd;
      wbw_log[cyc] <= wb_reg_write_en;
      sv0_log[cyc] <= stage_valid[0];
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       output int stalls);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    id_valid = 1'b1; id_opcode = opc; id_funct3 = f3; id_funct7 = f7;
    id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = (id_ready === 1'b1);
      @(posedge clk); #1;
      n++;
    end
    stalls = n - 1;
    if (!acc) begin
      n_checks++;
      n_errors++;
      $display("FAIL issue_timeout: id_ready low for %0d cycles, required acceptance", n);
    end
    id_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    id_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; id_valid = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    rst = 1'b1; flush = 1'b0; id_valid = 1'b1;
    id_opcode = O_IMM; id_funct3 = 3'd0; id_funct7 = 7'h00; id_rd = 5'd5; id_rs1 = 5'd0; id_rs2 = 5'd0;
    repeat (2) @(posedge clk); #1;
    chk("reset_stage_valid", 32'(stage_valid), 0);
    chk("reset_stall_cnt", 32'(stall_cnt), 0);
    chk("reset_id_ready", 32'(id_ready), 1);
    chk("reset_wb_reg_write_en", 32'(wb_reg_write_en), 0);
    rst = 1'b0;

    // addi x5,x0,3 ; add x6,x5,x5
    issue(O_IMM, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, st);
    issue(O_OP, 3'd0, 7'h00, 5'd6, 5'd5, 5'd5, st);
    chk("alu_stalls", 32'(st), FWD ? 0 : 2);
    idle(6);
    chk("alu_wb_rd_c3", 32'(wb_log[3]), 5);
    chk("alu_wb_rd_add", 32'(wb_log[FWD ? 4 : 6]), 6);
    chk("alu_stall_cnt", 32'(stall_cnt), FWD ? 0 : 2);

    // lw x7,0(x1) ; sub x8,x7,x2
    do_reset();
    issue(O_LOAD, 3'd2, 7'h00, 5'd7, 5'd1, 5'd0, st);
    issue(O_OP, 3'd0, 7'h20, 5'd8, 5'd7, 5'd2, st);
    chk("lu_stalls", 32'(st), FWD ? 1 : 2);
    idle(5);
    chk("lu_bubble_c2", 32'(sv0_log[2]), 0);
    chk("lu_stall_cnt", 32'(stall_cnt), FWD ? 1 : 2);

    // addi x0,x0,1 ; add x1,x0,x0
    do_reset();
    issue(O_IMM, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, st);
    issue(O_OP, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, st);
    chk("x0_stalls", 32'(st), 0);
    idle(5);
    chk("x0_wb_we_addi", 32'(wbw_log[3]), 0);
    chk("x0_wb_we_add", 32'(wbw_log[4]), 1);

    // flush while a load-use hazard is pending
    do_reset();
    issue(O_LOAD, 3'd2, 7'h00, 5'd7, 5'd1, 5'd0, st);
    id_valid = 1'b1; id_opcode = O_OP; id_funct3 = 3'd0; id_funct7 = 7'h20;
    id_rd = 5'd8; id_rs1 = 5'd7; id_rs2 = 5'd2; flush = 1'b1;
    @(negedge clk);
    chk("flush_id_ready", 32'(id_ready), 1);
    @(posedge clk); #1;
    flush = 1'b0; id_valid = 1'b0;
    chk("flush_stage0_bubble", 32'(stage_valid[0]), 0);
    chk("flush_stall_cnt", 32'(stall_cnt), 0);
    idle(4);

    // illegal opcode and illegal OP funct7
    do_reset();
    issue(7'h7F, 3'd0, 7'h00, 5'd3, 5'd7, 5'd7, st);
    chk("illegal_opcode", 32'(illegal), 1);
    chk("illegal_stage0_valid", 32'(stage_valid[0]), 1);
    issue(O_OP, 3'd0, 7'h01, 5'd4, 5'd1, 5'd2, st);
    chk("illegal_funct7", 32'(illegal), 1);
    idle(4);
    chk("illegal_no_wb", 32'(wb_reg_write_en), 0);

    // mixed instruction stream, checked cycle by cycle against the model
    do_reset();
    issue(O_LUI,   3'd0, 7'h00, 5'd1,  5'd0, 5'd0, st);
    issue(O_AUIPC, 3'd0, 7'h00, 5'd2,  5'd0, 5'd0, st);
    issue(O_JAL,   3'd0, 7'h00, 5'd3,  5'd0, 5'd0, st);
    issue(O_IMM,   3'd0, 7'h00, 5'd4,  5'd1, 5'd0, st);
    issue(O_STORE, 3'd2, 7'h00, 5'd8,  5'd2, 5'd4, st);
    issue(O_BR,    3'd0, 7'h00, 5'd0,  5'd1, 5'd4, st);
    issue(O_IMM,   3'd1, 7'h00, 5'd5,  5'd4, 5'd2, st);
    issue(O_IMM,   3'd5, 7'h20, 5'd6,  5'd5, 5'd3, st);
    issue(O_OP,    3'd5, 7'h20, 5'd7,  5'd6, 5'd5, st);
    issue(O_OP,    3'd6, 7'h00, 5'd9,  5'd7, 5'd1, st);
    issue(O_OP,    3'd7, 7'h00, 5'd10, 5'd3, 5'd9, st);
    issue(O_OP,    3'd2, 7'h00, 5'd11, 5'd2, 5'd1, st);
    issue(O_OP,    3'd3, 7'h00, 5'd12, 5'd1, 5'd2, st);
    issue(O_OP,    3'd4, 7'h00, 5'd13, 5'd4, 5'd3, st);
    issue(O_OP,    3'd5, 7'h00, 5'd14, 5'd13, 5'd1, st);
    issue(O_JALR,  3'd0, 7'h00, 5'd15, 5'd14, 5'd0, st);
    issue(O_LOAD,  3'd2, 7'h00, 5'd0,  5'd15, 5'd0, st);
    issue(O_OP,    3'd0, 7'h00, 5'd16, 5'd0, 5'd0, st);
    issue(O_STORE, 3'd2, 7'h00, 5'd4,  5'd16, 5'd15, st);

    // reset with instructions in flight
    issue(O_IMM,  3'd0, 7'h00, 5'd17, 5'd0, 5'd0, st);
    issue(O_LOAD, 3'd2, 7'h00, 5'd18, 5'd1, 5'd0, st);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midreset_stage_valid", 32'(stage_valid), 0);
    idle(4);
    chk("midreset_no_wb", 32'(wb_reg_write_en), 0);

    // stall counter saturation at CNT_W=4
    do_reset();
    for (int k = 0; k < 20; k++) begin
      issue(O_LOAD, 3'd2, 7'h00, 5'd7, 5'd1, 5'd0, st);
      issue(O_OP, 3'd0, 7'h20, 5'd8, 5'd7, 5'd2, st);
    end
    idle(4);
    chk("stall_cnt_saturated", 32'(stall_cnt), 15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
